// File: rtl/decode_sequencer_if.sv
// Bus between the decode sequencer and its program ROM, ALU, accumulator and data RAM.
// master = sequencer side, slave = datapath/memory side.
interface decode_sequencer_if;
    logic [7:0]  prog_data;
    logic        alu_c;
    logic        alu_z;
    logic [11:0] pc;
    logic [2:0]  alu_f;
    logic [3:0]  imm;
    logic [11:0] ram_addr;
    logic        src_ram;
    logic        load_accu;
    logic        ram_we;
    logic        c_flag;
    logic        z_flag;
    logic        halted;

    modport master (
        input  prog_data, alu_c, alu_z,
        output pc, alu_f, imm, ram_addr, src_ram, load_accu, ram_we,
               c_flag, z_flag, halted
    );

    modport slave (
        output prog_data, alu_c, alu_z,
        input  pc, alu_f, imm, ram_addr, src_ram, load_accu, ram_we,
               c_flag, z_flag, halted
    );
endinterface

// File: rtl/decode_sequencer.sv
// Fetch/decode control for the 4-bit processor: fetches one or two program bytes,
// then drives ALU/memory enables for a single EXEC cycle and steers the pc.
module decode_sequencer #(
    parameter logic [11:0] RESET_VECTOR = 12'h000
) (
    input  logic               clock,
    input  logic               reset,
    decode_sequencer_if.master bus
);
    typedef enum logic [1:0] {ST_FETCH, ST_FETCH2, ST_EXEC, ST_HALT} state_t;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  op2_q, op2_d;
    logic        c_q, c_d;
    logic        z_q, z_d;

    logic [2:0]  alu_f;
    logic        src_ram;
    logic        load_accu;
    logic        ram_we;
    logic        load_flags;
    logic        take_jump;
    logic [3:0]  opcode;
    logic [3:0]  fetch_opcode;
    logic [11:0] operand_addr;
    logic [11:0] pc_inc;

    assign opcode       = ir_q[7:4];
    assign fetch_opcode = bus.prog_data[7:4];
    assign operand_addr = {ir_q[3:0], op2_q};
    assign pc_inc       = pc_q + 12'd1;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        op2_d      = op2_q;
        c_d        = c_q;
        z_d        = z_q;
        alu_f      = 3'b000;
        src_ram    = 1'b0;
        load_accu  = 1'b0;
        ram_we     = 1'b0;
        load_flags = 1'b0;
        take_jump  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                ir_d    = bus.prog_data;
                pc_d    = pc_inc;
                // Opcodes 5..B carry a second address byte.
                state_d = ((fetch_opcode >= 4'h5) && (fetch_opcode <= 4'hB)) ? ST_FETCH2 : ST_EXEC;
            end
            ST_FETCH2: begin
                op2_d   = bus.prog_data;
                pc_d    = pc_inc;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    4'h1: begin alu_f = 3'b010; load_accu = 1'b1; load_flags = 1'b1; end
                    4'h2: begin alu_f = 3'b011; load_accu = 1'b1; load_flags = 1'b1; end
                    4'h3: begin alu_f = 3'b001; load_flags = 1'b1; end
                    4'h4: begin alu_f = 3'b100; load_accu = 1'b1; load_flags = 1'b1; end
                    4'h5: begin alu_f = 3'b010; src_ram = 1'b1; load_accu = 1'b1; load_flags = 1'b1; end
                    4'h6: begin alu_f = 3'b000; ram_we = 1'b1; end
                    4'h7: begin alu_f = 3'b011; src_ram = 1'b1; load_accu = 1'b1; load_flags = 1'b1; end
                    4'h8: take_jump = 1'b1;
                    4'h9: take_jump = c_q;
                    4'hA: take_jump = z_q;
                    4'hB: take_jump = ~z_q;
                    default: ;
                endcase
                if (load_flags) begin
                    c_d = bus.alu_c;
                    z_d = bus.alu_z;
                end
                if (take_jump) begin
                    pc_d = operand_addr;
                end
                state_d = (opcode == 4'hF) ? ST_HALT : ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_VECTOR;
            ir_q    <= 8'h00;
            op2_q   <= 8'h00;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            op2_q   <= op2_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.alu_f     = alu_f;
    assign bus.imm       = ir_q[3:0];
    assign bus.ram_addr  = operand_addr;
    assign bus.src_ram   = src_ram;
    assign bus.load_accu = load_accu;
    assign bus.ram_we    = ram_we;
    assign bus.c_flag    = c_q;
    assign bus.z_flag    = z_q;
    assign bus.halted    = (state_q == ST_HALT);
endmodule

// File: tb/tb_decode_sequencer.sv
// Random and directed programs run on the sequencer with a 4-bit ALU/accu/RAM environment;
// an instruction-level model fills a scoreboard that a negedge monitor drains.
module tb_decode_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rst2  = 1'b1;
    always #5 clock = ~clock;

    decode_sequencer_if sif ();
    decode_sequencer_if sif2 ();

    decode_sequencer dut (.clock(clock), .reset(reset), .bus(sif));
    decode_sequencer #(.RESET_VECTOR(12'hFFF)) dut_rv (.clock(clock), .reset(rst2), .bus(sif2));

    typedef struct {
        logic [11:0] pc_start;
        logic [7:0]  opbyte;
        int          ncyc;
        logic [2:0]  f;
        logic        sr;
        logic        sr_care;
        logic        la;
        logic        we;
        logic [11:0] addr;
        logic [3:0]  imm;
        logic [11:0] pc_after;
        logic        c;
        logic        z;
        logic [3:0]  acc;
        logic        halt;
        logic        first;
    } rec_t;

    rec_t       sb_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         mon_done = 0;

    logic [7:0] rom [4096];
    bit   [3:0] env_ram [4096];
    bit   [3:0] env_accu;
    logic [3:0] env_bus;
    logic [3:0] env_s;
    logic       env_c;
    logic       env_z;

    // {carry, zero, result}: 010 pass bus, 011 add, 001 compare (borrow), 100 nand, else pass accu
    function automatic logic [5:0] alu_eval(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] t;
        logic [3:0] s;
        logic       c;
        c = 1'b0;
        t = 5'd0;
        case (f)
            3'b010: s = b;
            3'b011: begin t = {1'b0, a} + {1'b0, b}; s = t[3:0]; c = t[4]; end
            3'b001: begin s = a - b; c = (a < b); end
            3'b100: s = ~(a & b);
            default: s = a;
        endcase
        return {c, (s == 4'd0), s};
    endfunction

    assign sif.prog_data  = rom[sif.pc];
    assign env_bus        = sif.src_ram ? env_ram[sif.ram_addr] : sif.imm;
    assign {env_c, env_z, env_s} = alu_eval(sif.alu_f, env_accu, env_bus);
    assign sif.alu_c      = env_c;
    assign sif.alu_z      = env_z;
    assign sif2.prog_data = rom[sif2.pc];
    assign sif2.alu_c     = 1'b0;
    assign sif2.alu_z     = 1'b0;

    always @(posedge clock) begin
        if (!reset) begin
            if (sif.load_accu) env_accu <= env_s;
            if (sif.ram_we) env_ram[sif.ram_addr] <= env_s;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string name);
        chk(name, 32'({sif.alu_f, sif.src_ram, sif.load_accu, sif.ram_we}), 32'd0);
    endtask

    // Instruction-level model of a program run from pc 0; one scoreboard entry per instruction.
    task automatic run_model(input int max_instr, output int n);
        bit   [3:0]  mram [4096];
        logic [11:0] pc, nxt, a, p1;
        logic [7:0]  b, o2;
        logic [3:0]  op, k, acc, busv;
        logic        c, z, two, taken, lf;
        logic [5:0]  res;
        rec_t        r;
        mram = env_ram;
        acc  = env_accu;
        c = 1'b0; z = 1'b0; pc = 12'h000; n = 0;
        for (int i = 0; i < max_instr; i++) begin
            b   = rom[pc];
            op  = b[7:4];
            k   = b[3:0];
            two = op inside {[4'h5:4'hB]};
            p1  = pc + 12'd1;
            o2  = two ? rom[p1] : 8'h00;
            nxt = two ? pc + 12'd2 : p1;
            a   = {k, o2};
            r.pc_start = pc; r.opbyte = b; r.ncyc = two ? 3 : 2;
            r.f = 3'b000; r.sr = 1'b0; r.la = 1'b0; r.we = 1'b0;
            r.sr_care = (op != 4'h6); r.addr = a; r.imm = k;
            r.halt = (op == 4'hF); r.first = (i == 0);
            lf = 1'b0; taken = 1'b0;
            case (op)
                4'h1: begin r.f = 3'b010; r.la = 1'b1; lf = 1'b1; end
                4'h2: begin r.f = 3'b011; r.la = 1'b1; lf = 1'b1; end
                4'h3: begin r.f = 3'b001; lf = 1'b1; end
                4'h4: begin r.f = 3'b100; r.la = 1'b1; lf = 1'b1; end
                4'h5: begin r.f = 3'b010; r.sr = 1'b1; r.la = 1'b1; lf = 1'b1; end
                4'h6: r.we = 1'b1;
                4'h7: begin r.f = 3'b011; r.sr = 1'b1; r.la = 1'b1; lf = 1'b1; end
                4'h8: taken = 1'b1;
                4'h9: taken = c;
                4'hA: taken = z;
                4'hB: taken = !z;
                default: ;
            endcase
            busv = r.sr ? mram[a] : k;
            res  = alu_eval(r.f, acc, busv);
            if (r.la) acc = res[3:0];
            if (r.we) mram[a] = res[3:0];
            if (lf) begin c = res[5]; z = res[4]; end
            pc = taken ? a : nxt;
            r.pc_after = pc; r.c = c; r.z = z; r.acc = acc;
            sb_q.push_back(r);
            n++;
            if (r.halt) break;
        end
    endtask

    initial begin : monitor
        rec_t r;
        forever begin
            while (sb_q.size() == 0) @(negedge clock);
            r = sb_q.pop_front();
            if (r.first) while (reset) @(negedge clock);
            chk("pc_fetch", 32'(sif.pc), 32'(r.pc_start));
            chk_idle("idle_fetch");
            if (r.ncyc == 3) begin
                @(negedge clock);
                chk_idle("idle_fetch2");
            end
            @(negedge clock);
            chk("exec_alu_f", 32'(sif.alu_f), 32'(r.f));
            chk("exec_load_accu", 32'(sif.load_accu), 32'(r.la));
            chk("exec_ram_we", 32'(sif.ram_we), 32'(r.we));
            chk("exec_imm", 32'(sif.imm), 32'(r.imm));
            chk("exec_halted", 32'(sif.halted), 32'd0);
            if (r.sr_care) chk("exec_src_ram", 32'(sif.src_ram), 32'(r.sr));
            if (r.we || r.sr) chk("exec_ram_addr", 32'(sif.ram_addr), 32'(r.addr));
            @(negedge clock);
            chk("pc_next", 32'(sif.pc), 32'(r.pc_after));
            chk("c_flag", 32'(sif.c_flag), 32'(r.c));
            chk("z_flag", 32'(sif.z_flag), 32'(r.z));
            chk("accu", 32'(env_accu), 32'(r.acc));
            chk("halted", 32'(sif.halted), 32'(r.halt));
            if (r.halt) begin
                repeat (20) begin
                    @(negedge clock);
                    chk("halt_pc", 32'(sif.pc), 32'(r.pc_after));
                    chk("halt_flag", 32'(sif.halted), 32'd1);
                    chk_idle("halt_idle");
                end
            end
            $display("txn pc=%03h byte=%02h next_pc=%03h c=%0d z=%0d accu=%0h halt=%0d",
                     r.pc_start, r.opbyte, r.pc_after, r.c, r.z, r.acc, r.halt);
            mon_done++;
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    // Enters and leaves with reset asserted.
    task automatic do_run(input int max_instr);
        int n;
        int target;
        int cyc;
        run_model(max_instr, n);
        target = mon_done + n;
        @(posedge clock);
        #1 reset = 1'b0;
        cyc = 0;
        while (mon_done < target && cyc < 3000) begin
            @(posedge clock);
            cyc++;
        end
        if (mon_done < target) begin
            failures++;
            $display("FAIL run_timeout: got %0d instructions expected %0d", mon_done, target);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
        #1 reset = 1'b1;
        #1;
    endtask

    initial begin : stimulus
        logic [11:0] seq[$];
        logic [11:0] exp_seq [5];
        bit   [3:0]  saved;
        exp_seq = '{12'hFFF, 12'h000, 12'h001, 12'h002, 12'h3C0};
        clear_rom();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_pc", 32'(sif.pc), 32'h000);
        chk("rst_halted", 32'(sif.halted), 32'd0);
        chk("rst_flags", 32'({sif.c_flag, sif.z_flag}), 32'd0);
        chk_idle("rst_idle");
        chk("rst_rv_pc", 32'(sif2.pc), 32'hFFF);

        // LIT 5; ADDI C; JC 0x123 -> HALT
        rom[0] = 8'h15; rom[1] = 8'h2C; rom[2] = 8'h91; rom[3] = 8'h23; rom[12'h123] = 8'hF0;
        do_run(10);
        chk("p1_accu", 32'(env_accu), 32'h1);

        // LIT 7; CMPI 7/9; JZ 0x040; JNZ 0x050
        clear_rom();
        rom[0] = 8'h17; rom[1] = 8'h37; rom[2] = 8'hA0; rom[3] = 8'h40;
        rom[4] = 8'hB0; rom[5] = 8'h50; rom[12'h040] = 8'hF0; rom[12'h050] = 8'hF0;
        do_run(10);
        rom[1] = 8'h39;
        do_run(10);

        // LIT 3; CMPI 5; ST 0x2AB; HALT
        clear_rom();
        rom[0] = 8'h13; rom[1] = 8'h35; rom[2] = 8'h62; rom[3] = 8'hAB; rom[4] = 8'hF0;
        do_run(10);
        chk("st_ram", 32'(env_ram[12'h2AB]), 32'h3);

        // JMP 0x010; HALT at 0x010
        clear_rom();
        rom[0] = 8'h80; rom[1] = 8'h10; rom[12'h010] = 8'hF0;
        do_run(10);
        chk("halt_rst_pc", 32'(sif.pc), 32'h000);
        chk("halt_rst_halted", 32'(sif.halted), 32'd0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
            do_run(40);
        end

        // Reset asserted during the EXEC cycle of ST 0x005
        clear_rom();
        rom[0] = 8'h60; rom[1] = 8'h05;
        saved = env_ram[12'h005];
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("st_exec_we", 32'(sif.ram_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_we", 32'(sif.ram_we), 32'd0);
        chk("rst_async_la", 32'(sif.load_accu), 32'd0);
        chk("rst_async_pc", 32'(sif.pc), 32'h000);
        @(posedge clock);
        #1;
        chk("rst_no_write", 32'(env_ram[12'h005]), 32'(saved));
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rel_pc", 32'(sif.pc), 32'h000);
        chk("rel_flags", 32'({sif.c_flag, sif.z_flag, sif.halted}), 32'd0);
        chk_idle("rel_idle");
        @(posedge clock);
        #1 reset = 1'b1;

        // RESET_VECTOR = FFF: NOP at FFF, JMP 0x3C0 at 000
        clear_rom();
        rom[12'hFFF] = 8'h00; rom[0] = 8'h83; rom[1] = 8'hC0; rom[12'h3C0] = 8'hF0;
        @(posedge clock);
        #1 rst2 = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (seq.size() == 0 || seq[$] != sif2.pc) seq.push_back(sif2.pc);
        end
        chk("rv_seq_len", 32'(seq.size()), 32'd5);
        for (int i = 0; i < 5 && i < seq.size(); i++) chk("rv_seq_pc", 32'(seq[i]), 32'(exp_seq[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
